// File: rtl/uart_receiver_pkg.sv
// Shared definitions for the UART receive path: FSM encoding, default line rate
// and where the receiver shows up in the SoC IO page.
package uart_receiver_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } rx_state_t;

   localparam int DEFAULT_CLK_FREQ_HZ = 10_000_000;
   localparam int DEFAULT_BAUD_RATE   = 1_000_000;

   // IO page: RX data register returns o_data in [7:0]; status register bits below.
   localparam logic [7:0] IO_UART_RX_DATA       = 8'h10;
   localparam logic [7:0] IO_UART_RX_STATUS     = 8'h14;
   localparam int         RX_STAT_VALID_BIT     = 0;
   localparam int         RX_STAT_OVERRUN_BIT   = 1;
   localparam int         RX_STAT_FRAME_ERR_BIT = 2;

   function automatic int baud_div(input int freq_hz, input int rate);
      return freq_hz / rate;
   endfunction

endpackage

// File: rtl/uart_receiver_rx_fifo.sv
// Register-based receive FIFO. When empty the output holds the last byte popped
// so downstream never sees a stale slot or an unknown value.
module rx_fifo #(
   parameter int depth = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [7:0]               din,
   output logic [7:0]               dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(depth):0]   count
);
   localparam int AW   = $clog2(depth);
   localparam int CNTW = AW + 1;

   logic [7:0]    mem [depth];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [7:0]    hold;
   logic          do_push, do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CNTW'(depth));
   assign do_pop  = pop & ~empty;
   // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
   assign do_push = push & (~full | do_pop);
   assign dout    = empty ? hold : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         hold   <= '0;
         for (int i = 0; i < depth; i++) mem[i] <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            hold   <= mem[rd_ptr];
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (do_push && !do_pop)
            count <= count + 1'b1;
         else if (!do_push && do_pop)
            count <= count - 1'b1;
      end
   end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: synchronizer, mid-bit sampling FSM, register FIFO and
// sticky overrun / framing-error flags.
module uart_receiver
   import uart_receiver_pkg::*;
#(
   parameter int clk_freq_hz = DEFAULT_CLK_FREQ_HZ,
   parameter int baud_rate   = DEFAULT_BAUD_RATE,
   parameter int depth       = 4
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_uart_rx,
   output logic [7:0] o_data,
   output logic       o_valid,
   input  logic       i_ready,
   input  logic       i_clr_err,
   output logic       o_overrun,
   output logic       o_frame_err
);
   localparam int DIV = baud_div(clk_freq_hz, baud_rate);
   localparam int CW  = $clog2(DIV + 1);

   rx_state_t          state, state_nx;
   logic               sync1, sync2, rx_prev;
   logic [CW-1:0]      baud_cnt;
   logic [2:0]         bit_cnt;
   logic [7:0]         shreg;
   logic               fall, tick;
   logic               load_half, load_full, sample_bit, push_req, frame_set;
   logic               fifo_full, fifo_empty, pop_eff, lost;
   logic [$clog2(depth):0] fifo_count;

   assign fall    = rx_prev & ~sync2;
   assign tick    = (baud_cnt == '0);
   assign pop_eff = i_ready & ~fifo_empty;
   assign lost    = push_req & fifo_full & ~pop_eff;
   assign o_valid = (fifo_count != '0);

   always_comb begin
      state_nx   = state;
      load_half  = 1'b0;
      load_full  = 1'b0;
      sample_bit = 1'b0;
      push_req   = 1'b0;
      frame_set  = 1'b0;
      unique case (state)
         ST_IDLE:  if (fall) begin
                      state_nx  = ST_START;
                      load_half = 1'b1;
                   end
         // Re-check the start bit at its centre; a high line means it was a glitch.
         ST_START: if (tick) begin
                      if (!sync2) begin
                         state_nx  = ST_DATA;
                         load_full = 1'b1;
                      end else begin
                         state_nx  = ST_IDLE;
                      end
                   end
         ST_DATA:  if (tick) begin
                      sample_bit = 1'b1;
                      load_full  = 1'b1;
                      if (bit_cnt == 3'd7) state_nx = ST_STOP;
                   end
         ST_STOP:  if (tick) begin
                      state_nx  = ST_IDLE;
                      push_req  = sync2;
                      frame_set = ~sync2;
                   end
         default:  state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state       <= ST_IDLE;
         sync1       <= 1'b1;
         sync2       <= 1'b1;
         rx_prev     <= 1'b1;
         baud_cnt    <= '0;
         bit_cnt     <= '0;
         shreg       <= '0;
         o_overrun   <= 1'b0;
         o_frame_err <= 1'b0;
      end else begin
         state   <= state_nx;
         sync1   <= i_uart_rx;
         sync2   <= sync1;
         rx_prev <= sync2;
         if (load_half)
            baud_cnt <= CW'(DIV / 2 - 1);
         else if (load_full)
            baud_cnt <= CW'(DIV - 1);
         else if (!tick)
            baud_cnt <= baud_cnt - 1'b1;
         if (load_half)
            bit_cnt <= '0;
         else if (sample_bit)
            bit_cnt <= bit_cnt + 1'b1;
         if (sample_bit)
            shreg <= {sync2, shreg[7:1]};
         // Setting events take priority over a clear in the same cycle.
         o_overrun   <= lost      | (o_overrun   & ~i_clr_err);
         o_frame_err <= frame_set | (o_frame_err & ~i_clr_err);
      end
   end

   rx_fifo #(.depth(depth)) u_fifo (
      .clk   (i_clk),
      .rst   (i_rst),
      .push  (push_req),
      .pop   (i_ready),
      .din   (shreg),
      .dout  (o_data),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: frame-level reference model (queue of expected bytes,
// scheduled frame outcomes) compared every cycle, plus directed literal checks.
module tb_uart_receiver;
   localparam int CLK_HZ = 10_000_000;
   localparam int BAUD   = 1_000_000;
   localparam int DEPTH  = 4;
   localparam int DIV    = CLK_HZ / BAUD;
   // Stop-bit sample edge, in cycles after the start bit is driven:
   // 2 sync flops + 1 edge detect + half bit + 8 data bits + stop bit.
   localparam int LAT    = 2 + 1 + DIV / 2 + 8 * DIV + DIV;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx  = 1'b1;
   logic       rdy = 1'b0;
   logic       clr = 1'b0;
   logic [7:0] data;
   logic       valid, ovr, fe;

   always #50 clk = ~clk;

   uart_receiver #(.clk_freq_hz(CLK_HZ), .baud_rate(BAUD), .depth(DEPTH)) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_uart_rx   (rx),
      .o_data      (data),
      .o_valid     (valid),
      .i_ready     (rdy),
      .i_clr_err   (clr),
      .o_overrun   (ovr),
      .o_frame_err (fe)
   );

   typedef struct {
      int         cyc;
      logic [7:0] d;
      bit         good;
   } ev_t;

   ev_t        ev_q[$];
   logic [7:0] m_q[$];
   logic [7:0] m_hold = 8'h00;
   bit         m_ovr = 1'b0, m_fe = 1'b0, m_live = 1'b0;
   int         cyc = 0;
   int         checks = 0, errors = 0;
   bit         rand_rdy = 1'b0, rand_clr = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   // Reference model: one update per clock edge using the inputs held over the past cycle.
   always @(posedge clk) begin : model
      bit   pop, ps, set_o, set_f;
      ev_t  e;
      cyc = cyc + 1;
      if (rst) begin
         m_q.delete();
         ev_q.delete();
         m_hold = 8'h00;
         m_ovr  = 1'b0;
         m_fe   = 1'b0;
         m_live = 1'b1;
      end else begin
         pop   = (m_q.size() > 0) && rdy;
         ps    = 1'b0;
         set_o = 1'b0;
         set_f = 1'b0;
         e     = '{0, 8'h00, 1'b0};
         if (ev_q.size() > 0 && ev_q[0].cyc == cyc) begin
            e = ev_q.pop_front();
            if (!e.good)                        set_f = 1'b1;
            else if (m_q.size() < DEPTH || pop) ps    = 1'b1;
            else                                set_o = 1'b1;
         end
         if (pop) m_hold = m_q.pop_front();
         if (ps)  m_q.push_back(e.d);
         m_ovr = set_o | (m_ovr & ~clr);
         m_fe  = set_f | (m_fe  & ~clr);
      end
   end

   always @(negedge clk) begin
      if (m_live) begin
         chk("cmp_valid", 32'(valid), 32'(m_q.size() > 0));
         chk("cmp_data",  32'(data),  32'(m_q.size() > 0 ? m_q[0] : m_hold));
         chk("cmp_overrun", 32'(ovr), 32'(m_ovr));
         chk("cmp_frame_err", 32'(fe), 32'(m_fe));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      if (rand_rdy) rdy = ($urandom_range(0, 2) == 0);
      if (rand_clr) clr = ($urandom_range(0, 30) == 0);
   endtask

   task automatic send_frame(input logic [7:0] b, input bit good, input bit pulse);
      int k;
      k = cyc;
      ev_q.push_back('{k + LAT, b, good});
      rx = 1'b0;
      repeat (DIV) tick();
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (DIV) tick();
      end
      rx = good;
      for (int t = 0; t < DIV; t++) begin
         if (pulse) rdy = (cyc == k + LAT - 1);
         tick();
      end
      rx = 1'b1;
      if (!good) tick();
   endtask

   task automatic glitch(input int len);
      rx = 1'b0;
      repeat (len) tick();
      rx = 1'b1;
      repeat (10) tick();
   endtask

   task automatic pop_expect(input logic [7:0] exp);
      chk("pop_valid", 32'(valid), 32'(1));
      chk("pop_data",  32'(data),  32'(exp));
      rdy = 1'b1;
      tick();
      rdy = 1'b0;
   endtask

   task automatic clr_pulse();
      clr = 1'b1;
      tick();
      clr = 1'b0;
   endtask

   initial begin
      logic [7:0] b7e;
      int r;
      b7e = 8'h7E;
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      chk("rst_valid", 32'(valid), 32'(0));
      chk("rst_data",  32'(data),  32'(0));
      chk("rst_overrun", 32'(ovr), 32'(0));
      chk("rst_frame_err", 32'(fe), 32'(0));

      send_frame(8'h41, 1'b1, 1'b0);
      chk("f41_valid", 32'(valid), 32'(1));
      chk("f41_data",  32'(data),  32'(8'h41));
      chk("f41_flags", 32'({ovr, fe}), 32'(0));
      pop_expect(8'h41);
      chk("f41_empty", 32'(valid), 32'(0));

      glitch(3);
      chk("glitch_valid", 32'(valid), 32'(0));

      send_frame(8'h55, 1'b0, 1'b0);
      chk("ferr_valid", 32'(valid), 32'(0));
      chk("ferr_set",   32'(fe),    32'(1));
      clr_pulse();
      chk("ferr_clear", 32'(fe),    32'(0));

      for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b0);
      chk("ovr_set", 32'(ovr), 32'(1));
      for (int i = 1; i <= 4; i++) pop_expect(8'(i));
      chk("ovr_drained", 32'(valid), 32'(0));
      chk("ovr_hold",    32'(data),  32'(8'h04));
      clr_pulse();
      chk("ovr_clear", 32'(ovr), 32'(0));

      for (int i = 0; i < 4; i++) send_frame(8'(8'h21 + i), 1'b1, 1'b0);
      send_frame(8'h06, 1'b1, 1'b1);
      chk("full_pp_no_ovr", 32'(ovr), 32'(0));
      pop_expect(8'h22);
      pop_expect(8'h23);
      pop_expect(8'h24);
      pop_expect(8'h06);
      chk("full_pp_empty", 32'(valid), 32'(0));

      // Abandon 0x7E partway through data bit 4 with a reset, then resend it whole.
      rx = 1'b0;
      repeat (DIV) tick();
      for (int i = 0; i < 4; i++) begin
         rx = b7e[i];
         repeat (DIV) tick();
      end
      rx = b7e[4];
      repeat (3) tick();
      rst = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      rx  = 1'b1;
      repeat (120) tick();
      chk("midrst_valid", 32'(valid), 32'(0));
      chk("midrst_flags", 32'({ovr, fe}), 32'(0));
      send_frame(8'h7E, 1'b1, 1'b0);
      chk("f7e_valid", 32'(valid), 32'(1));
      chk("f7e_data",  32'(data),  32'(8'h7E));
      pop_expect(8'h7E);

      rand_rdy = 1'b1;
      rand_clr = 1'b1;
      repeat (60) begin
         r = $urandom_range(0, 9);
         if (r == 0) glitch($urandom_range(1, 3));
         else        send_frame(8'($urandom), (r != 1), 1'b0);
         repeat ($urandom_range(0, 8)) tick();
      end
      rand_rdy = 1'b0;
      rand_clr = 1'b0;
      rdy = 1'b1;
      clr = 1'b0;
      repeat (20) tick();
      rdy = 1'b0;
      tick();
      chk("final_empty", 32'(valid), 32'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
